regfile_axi_arbiter: RTL
========================

Name: regfile_axi_arbiter

Overview:
- Shares the single AXI-lite slave port of the 16-bit register file (coordinate/config regfile) between two requesters, e.g. host command path and display scan engine.
- Accepts simple word-indexed read/write requests and arbitrates round-robin.
- Runs one AXI-lite transaction at a time as master.
- Returns read data and error status with a one-cycle done pulse.

Parameters:
DATA_WIDTH, 16, data word width; matches regfile width.
AXI_LITE_ADDR_WIDTH, 8, AXI byte-address width.
IDX_WIDTH, 6, requester word-index width; IDX_WIDTH+2 <= AXI_LITE_ADDR_WIDTH is required.

Ports:
aclk  in  1  clock.
resetn  in  1  reset; one clock, reset asynchronous active-low.
req  in  2  per-requester request; held until done.
req_we  in  2  1=write, 0=read; stable while req high.
req_idx  in  2*IDX_WIDTH  word index; requester n uses slice [n*IDX_WIDTH +: IDX_WIDTH].
req_wdata  in  2*DATA_WIDTH  write data; slice per requester.
done  out  2  one-cycle completion pulse to the granted requester.
rsp_rdata  out  DATA_WIDTH  read data; valid while done != 0.
rsp_err  out  1  1 when AXI resp != 2'b00; valid with done.
busy  out  1  high in any state except IDLE.
araddr/arvalid out, arready in  AXI read address channel.
rdata/rresp/rvalid in, rready out  AXI read data channel.
awaddr/awvalid out, awready in  AXI write address channel.
wdata/wvalid out, wready in  AXI write data channel.
bresp/bvalid in, bready out  AXI write response channel.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, all valid/ready outputs 0, done=0, rsp_err=0, rsp_rdata=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Abandoning an in-flight AXI transaction on reset is accepted; the slave resets on the same resetn.
- Address formation: byte address = zero-extended {idx, 2'b00}, registered when the grant is taken.
- All AXI master outputs are registered; no combinational path from any input to any output.
- IDLE:
  - If req has any bit set: grant the only requester asserting it; if both assert, grant the one != last_grant.
  - Latch granted id, we, address and wdata.
  - Next state is WR if we=1, else RD_A.
  - In the same transition, assert awvalid+wvalid (WR) or arvalid (RD_A).
- WR:
  - awvalid and wvalid are held independently.
  - awvalid deasserts the cycle after awvalid&&awready; wvalid likewise for wvalid&&wready.
  - The two handshakes may complete in either order or the same cycle.
  - When both are complete, assert bready and go to WR_B.
- WR_B: on bvalid&&bready, capture rsp_err=(bresp!=0), deassert bready, go to DONE.
- RD_A: on arvalid&&arready, deassert arvalid, assert rready, go to RD_D.
- RD_D: on rvalid&&rready, capture rsp_rdata=rdata and rsp_err=(rresp!=0), deassert rready, go to DONE.
- DONE (one cycle):
  - done[granted]=1 for exactly one cycle; last_grant=granted.
  - Return to IDLE. A new grant is possible on the cycle after DONE.
  - rsp_rdata/rsp_err hold their values until the next capture.
  - For writes, rsp_rdata is unchanged.
- Requester rule: deassert req on the cycle after done, or keep it high to issue a new request, which re-arbitrates.
- Requests arriving while busy wait; a change of req during a granted transaction is ignored.
- Minimum latency, slave ready and responding immediately:
  - Read: req -> done in 4 cycles (IDLE, RD_A, RD_D, DONE); longer against the regfile because of its fetch cycle.
  - Write: 4 cycles (IDLE, WR, WR_B, DONE).
- Fairness: under continuous requests from both, grants strictly alternate 0,1,0,1.
- Illegal state encodings recover to IDLE with all valids low.

Decomposition:
- Shared package regfile_axi_pkg holds:
  - state enum (IDLE, WR, WR_B, RD_A, RD_D, DONE);
  - AXI_OK=2'b00, AXI_ERR=2'b10;
  - function idx_to_addr.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant register.
- The transaction FSM stays in the top module.

Test Plan:
1. Reset, then req[0] read idx 3 against the regfile with initial contents -> araddr=8'h0C, done[0] one cycle, rsp_rdata=16'd500, rsp_err=0.
2. req[1] write idx 5, wdata 16'h1234, then req[0] read idx 5 -> awaddr=8'h14, wdata=16'h1234, done[1] then done[0], rsp_rdata=16'h1234.
3. Both req high continuously after reset for 4 transactions -> grant order 0,1,0,1; done never pulses two bits at once.
4. Slave model with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one write, bready only after both handshakes.
5. Slave returns rresp=2'b10 for a read of idx 40 -> rsp_err=1 with done; the next OK read clears rsp_err=0.
6. resetn pulled low in RD_D while rready=1 -> rready, arvalid and done go 0 immediately. After release, both requesting -> requester 0 is served first.

Source files
------------

// File: rtl/regfile_axi_pkg.sv
// Shared definitions for the register-file AXI-lite arbiter.
// Contents:
//   state_t     - transaction FSM states
//   AXI_OK/ERR  - AXI-lite response codes
//   idx_to_addr - word index to byte address conversion
package regfile_axi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] AXI_OK  = 2'b00;
  localparam logic [1:0] AXI_ERR = 2'b10;

  // Word index to byte address; callers truncate to their address width.
  function automatic logic [31:0] idx_to_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/regfile_axi_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_req          - request vector from the two requesters
//   i_upd          - strobe: a transaction for i_upd_id has finished
//   i_upd_id       - requester that was just served
//   o_gnt_vld      - at least one request present
//   o_gnt_id       - requester that wins this cycle
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_id,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  logic r_last;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_upd) begin
      r_last <= i_upd_id;
    end
  end

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_id  = 1'b0;
    case (i_req)
      2'b01:   o_gnt_id = 1'b0;
      2'b10:   o_gnt_id = 1'b1;
      2'b11:   o_gnt_id = ~r_last;
      default: o_gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/regfile_axi_arbiter.sv
// Shares one AXI-lite master port between two word-indexed requesters.
// One transaction at a time, round-robin between requesters.
// Ports:
//   aclk, resetn            - clock, asynchronous active-low reset
//   req/req_we/req_idx/req_wdata - per-requester request (slices per requester)
//   done                    - one-cycle completion pulse to the served requester
//   rsp_rdata, rsp_err      - read data and error status, valid with done, held after
//   busy                    - FSM not in IDLE
//   ar*/r*/aw*/w*/b*        - AXI-lite master channels (all outputs registered)
module regfile_axi_arbiter
  import regfile_axi_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int IDX_WIDTH           = 6
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic [1:0]                     req,
  input  logic [1:0]                     req_we,
  input  logic [2*IDX_WIDTH-1:0]         req_idx,
  input  logic [2*DATA_WIDTH-1:0]        req_wdata,
  output logic [1:0]                     done,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] araddr,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rvalid,
  output logic                           rready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [DATA_WIDTH-1:0]          wdata,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready
);

  state_t                         r_state, w_state_nxt;
  logic                           r_id, w_id_nxt;
  logic [AXI_LITE_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]          r_wdata, w_wdata_nxt;
  logic                           r_awvalid, w_awvalid_nxt;
  logic                           r_wvalid, w_wvalid_nxt;
  logic                           r_arvalid, w_arvalid_nxt;
  logic                           r_rready, w_rready_nxt;
  logic                           r_bready, w_bready_nxt;
  logic [1:0]                     r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0]          r_rdata, w_rdata_nxt;
  logic                           r_err, w_err_nxt;

  logic                           w_gnt_vld, w_gnt_id;
  logic                           w_sel_we;
  logic [IDX_WIDTH-1:0]           w_sel_idx;
  logic [DATA_WIDTH-1:0]          w_sel_wdata;
  logic [1:0]                     w_done_vec;

  rr_arb2 u_arb (
    .i_clk     (aclk),
    .i_rst_n   (resetn),
    .i_req     (req),
    .i_upd     (r_state == DONE),
    .i_upd_id  (r_id),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  always_comb begin
    w_sel_we    = w_gnt_id ? req_we[1] : req_we[0];
    w_sel_idx   = w_gnt_id ? req_idx[IDX_WIDTH +: IDX_WIDTH] : req_idx[0 +: IDX_WIDTH];
    w_sel_wdata = w_gnt_id ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    w_done_vec  = r_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_id      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 2'b00;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_bready  <= w_bready_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Every output is a register, so each branch computes the value the
  // outputs take in the *next* state (valids rise on the grant edge, done
  // rises on the edge entering DONE).
  always_comb begin
    w_state_nxt   = r_state;
    w_id_nxt      = r_id;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_bready_nxt  = r_bready;
    w_done_nxt    = 2'b00;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_id_nxt    = w_gnt_id;
          w_addr_nxt  = AXI_LITE_ADDR_WIDTH'(idx_to_addr(32'(w_sel_idx)));
          w_wdata_nxt = w_sel_wdata;
          if (w_sel_we) begin
            w_state_nxt   = WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RD_A;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      WR: begin
        // Address and data handshakes complete independently, in any order.
        w_awvalid_nxt = r_awvalid & ~awready;
        w_wvalid_nxt  = r_wvalid & ~wready;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid && r_bready) begin
          w_err_nxt    = (bresp != AXI_OK);
          w_bready_nxt = 1'b0;
          w_done_nxt   = w_done_vec;
          w_state_nxt  = DONE;
        end
      end
      RD_A: begin
        if (r_arvalid && arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid && r_rready) begin
          w_rdata_nxt  = rdata;
          w_err_nxt    = (rresp != AXI_OK);
          w_rready_nxt = 1'b0;
          w_done_nxt   = w_done_vec;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
      end
    endcase
  end

  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = (r_state != IDLE);
  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign wdata     = r_wdata;
  assign arvalid   = r_arvalid;
  assign awvalid   = r_awvalid;
  assign wvalid    = r_wvalid;
  assign rready    = r_rready;
  assign bready    = r_bready;

endmodule
